// File: rtl/pipe_universal_adder_pkg.sv
// Shared encodings and result-flag bundle for the pipelined add/sub/compare unit.
package pipe_universal_adder_pkg;

   typedef enum logic [1:0] {
      ADD_MODE  = 2'b00,
      SUB_MODE  = 2'b01,
      SLT_MODE  = 2'b10,
      SLTU_MODE = 2'b11
   } mode_e;

   typedef struct packed {
      logic carry;
      logic overflow;
      logic zero;
      logic negative;
      logic lt;
   } flags_t;

endpackage

// File: rtl/pipe_universal_adder_adder_seg.sv
// One carry-chained segment of the adder; purely combinational.
module adder_seg #(
   parameter int SEG = 16
) (
   input  logic [SEG-1:0] a,
   input  logic [SEG-1:0] b,
   input  logic           cin,
   output logic [SEG-1:0] sum,
   output logic           cout
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};

endmodule

// File: rtl/pipe_universal_adder.sv
// Pipelined add/sub/slt/sltu: one SEG-wide carry segment per register stage,
// valid/ready on both sides, synchronous flush, async reset.
module pipe_universal_adder
   import pipe_universal_adder_pkg::*;
#(
   parameter int DATAWIDTH = 32,
   parameter int STAGES    = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DATAWIDTH-1:0] a,
   input  logic [DATAWIDTH-1:0] b,
   input  logic [1:0]           mode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DATAWIDTH-1:0] out,
   output logic                 carry,
   output logic                 overflow,
   output logic                 zero,
   output logic                 negative,
   output logic                 lt
);

   localparam int SEG = DATAWIDTH / STAGES;
   localparam int L   = STAGES - 1;

   // Bank j (1..STAGES) holds an op that has passed stage j-1; bank STAGES is the output.
   logic [STAGES:1]   vld_pipe;
   logic [STAGES:1]   vld_in;
   logic [STAGES+1:1] take;
   logic              accept;
   logic              in_sub;

   assign in_sub   = (mode != ADD_MODE);
   assign in_ready = take[1] && !flush;
   assign accept   = in_valid && in_ready;

   always_comb begin
      take = '0;
      take[STAGES+1] = out_ready;
      for (int j = STAGES; j >= 1; j--) take[j] = !vld_pipe[j] || take[j+1];
   end

   always_comb begin
      vld_in = '0;
      vld_in[1] = accept;
      for (int j = 2; j <= STAGES; j++) vld_in[j] = vld_pipe[j-1];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_pipe <= '0;
      end else if (flush) begin
         vld_pipe <= '0;
      end else begin
         for (int j = 1; j <= STAGES; j++)
            if (take[j]) vld_pipe[j] <= vld_in[j];
      end
   end

   // Operands shrink by one segment per stage; finished sum bits grow by one.
   for (genvar k = 0; k < STAGES; k++) begin : stg
      localparam int OW = DATAWIDTH - k*SEG;
      logic [OW-1:0]          ua, ub;
      logic [(k+1)*SEG-1:0]   res;
      logic [SEG-1:0]         ss;
      logic                   ci, co;
      logic [1:0]             md;

      if (k == 0) begin : src
         assign ua  = a;
         assign ub  = b ^ {DATAWIDTH{in_sub}};
         assign ci  = in_sub;
         assign md  = mode;
         assign res = ss;
      end else begin : src
         logic [OW-1:0]    ua_q, ub_q;
         logic [k*SEG-1:0] lo_q;
         logic             ci_q;
         logic [1:0]       md_q;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               ua_q <= '0;
               ub_q <= '0;
               lo_q <= '0;
               ci_q <= 1'b0;
               md_q <= '0;
            end else if (take[k] && vld_in[k]) begin
               ua_q <= stg[k-1].ua[OW+SEG-1:SEG];
               ub_q <= stg[k-1].ub[OW+SEG-1:SEG];
               lo_q <= stg[k-1].res;
               ci_q <= stg[k-1].co;
               md_q <= stg[k-1].md;
            end
         end

         assign ua  = ua_q;
         assign ub  = ub_q;
         assign ci  = ci_q;
         assign md  = md_q;
         assign res = {ss, lo_q};
      end

      adder_seg #(.SEG(SEG)) u_seg (
         .a    (ua[SEG-1:0]),
         .b    (ub[SEG-1:0]),
         .cin  (ci),
         .sum  (ss),
         .cout (co)
      );
   end

   logic [DATAWIDTH-1:0] sum_n, out_q;
   logic                 ovf_n, lt_n;
   flags_t               flg_q;

   // The last segment still carries the operand MSBs, so overflow is formed here.
   always_comb begin
      sum_n = stg[L].res;
      ovf_n = (stg[L].ua[SEG-1] == stg[L].ub[SEG-1]) &&
              (sum_n[DATAWIDTH-1] != stg[L].ua[SEG-1]);
      case (stg[L].md)
         SLT_MODE:  lt_n = sum_n[DATAWIDTH-1] ^ ovf_n;
         SLTU_MODE: lt_n = !stg[L].co;
         default:   lt_n = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q <= '0;
         flg_q <= '0;
      end else if (take[STAGES] && vld_in[STAGES]) begin
         out_q <= stg[L].md[1] ? {{(DATAWIDTH-1){1'b0}}, lt_n} : sum_n;
         flg_q <= '{carry:    stg[L].co,
                    overflow: ovf_n,
                    zero:     (sum_n == '0),
                    negative: sum_n[DATAWIDTH-1],
                    lt:       lt_n};
      end
   end

   assign out_valid = vld_pipe[STAGES];
   assign out       = out_q;
   assign carry     = flg_q.carry;
   assign overflow  = flg_q.overflow;
   assign zero      = flg_q.zero;
   assign negative  = flg_q.negative;
   assign lt        = flg_q.lt;

endmodule

// File: tb/tb_pipe_universal_adder.sv
// Directed bench: three instances (STAGES 1, 2, 4) on a shared input bus.
module tb_pipe_universal_adder;
   import pipe_universal_adder_pkg::*;

   localparam int W = 32;
   localparam int LAT [3] = '{1, 2, 4};

   typedef struct {
      logic [1:0]   m;
      logic [W-1:0] a, b, o;
      logic         c, ov, z, n, lt;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst, flush, in_valid, out_ready;
   logic [W-1:0] a, b;
   logic [1:0]   mode;

   logic         in_ready [3];
   logic         out_valid [3];
   logic [W-1:0] out_r [3];
   logic         carry [3], overflow [3], zero [3], negative [3], lt [3];
   logic [37:0]  obs [3];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   for (genvar i = 0; i < 3; i++) begin : g
      pipe_universal_adder #(.DATAWIDTH(W), .STAGES(LAT[i])) dut (
         .clk       (clk),
         .rst       (rst),
         .flush     (flush),
         .in_valid  (in_valid),
         .in_ready  (in_ready[i]),
         .a         (a),
         .b         (b),
         .mode      (mode),
         .out_valid (out_valid[i]),
         .out_ready (out_ready),
         .out       (out_r[i]),
         .carry     (carry[i]),
         .overflow  (overflow[i]),
         .zero      (zero[i]),
         .negative  (negative[i]),
         .lt        (lt[i])
      );
      assign obs[i] = {out_valid[i], out_r[i], carry[i], overflow[i], zero[i], negative[i], lt[i]};
   end

   task automatic test_reset();
      #2;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (obs[i] !== 38'h0) begin
            errors++;
            $display("FAIL reset S=%0d: got %h want 0", LAT[i], obs[i]);
         end
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_add_sub_cmp();
      vec_t        tv [10];
      logic [37:0] exp;
      tv[0] = '{ADD_MODE,  32'h0000FFFF, 32'h00000001, 32'h00010000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tv[1] = '{ADD_MODE,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      tv[2] = '{ADD_MODE,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      tv[3] = '{SUB_MODE,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      tv[4] = '{SUB_MODE,  32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      tv[5] = '{SLT_MODE,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      tv[6] = '{SLTU_MODE, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      tv[7] = '{SLTU_MODE, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      tv[8] = '{SLT_MODE,  32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tv[9] = '{SLT_MODE,  32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      out_ready = 1'b1;
      for (int v = 0; v < 10; v++) begin
         in_valid = 1'b1; a = tv[v].a; b = tv[v].b; mode = tv[v].m;
         @(posedge clk); #1;
         in_valid = 1'b0;
         exp = {1'b1, tv[v].o, tv[v].c, tv[v].ov, tv[v].z, tv[v].n, tv[v].lt};
         for (int t = 1; t <= 4; t++) begin
            for (int i = 0; i < 3; i++) begin
               if (LAT[i] == t) begin
                  checks++;
                  if (obs[i] !== exp) begin
                     errors++;
                     $display("FAIL vec%0d S=%0d: got %h want %h", v, LAT[i], obs[i], exp);
                  end
               end
            end
            if (t < 4) begin @(posedge clk); #1; end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0]  exp_rdy = 4'b0011;
      logic [37:0] exp;
      logic        rdy;
      int          acc = 0;
      out_ready = 1'b0;
      mode = ADD_MODE;
      for (int c = 0; c < 4; c++) begin
         in_valid = 1'b1; a = 32'(acc + 1); b = 32'(acc + 1);
         #1;
         rdy = in_ready[1];
         checks++;
         if (rdy !== exp_rdy[c]) begin
            errors++;
            $display("FAIL b2b_ready c%0d: got %b want %b", c, rdy, exp_rdy[c]);
         end
         @(posedge clk); if (rdy) acc++; #1;
         if (c >= 1) begin
            exp = {1'b1, 32'd2, 5'b00000};
            checks++;
            if (obs[1] !== exp) begin
               errors++;
               $display("FAIL b2b_hold c%0d: got %h want %h", c, obs[1], exp);
            end
         end
      end
      out_ready = 1'b1;
      for (int r = 0; r < 5; r++) begin
         if (acc < 4) begin
            in_valid = 1'b1; a = 32'(acc + 1); b = 32'(acc + 1);
         end else begin
            in_valid = 1'b0;
         end
         #1;
         rdy = in_valid && in_ready[1];
         checks++;
         if (r < 4) begin
            exp = {1'b1, 32'(2 * (r + 1)), 5'b00000};
            if (obs[1] !== exp) begin
               errors++;
               $display("FAIL b2b_drain r%0d: got %h want %h", r, obs[1], exp);
            end
         end else if (out_valid[1] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_extra: out_valid got %b want 0", out_valid[1]);
         end
         @(posedge clk); if (rdy) acc++; #1;
      end
   endtask

   task automatic test_flush();
      logic [37:0] exp;
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      out_ready = 1'b0; mode = ADD_MODE;
      in_valid = 1'b1; a = 32'd1; b = 32'd2;
      @(posedge clk); #1;
      a = 32'd3; b = 32'd4;
      @(posedge clk); #1;
      a = 32'd9; b = 32'd9; flush = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (in_ready[i] !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready S=%0d: got %b want 0", LAT[i], in_ready[i]);
         end
      end
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (out_valid[i] !== 1'b0) begin
            errors++;
            $display("FAIL flush_clear S=%0d: out_valid got %b want 0", LAT[i], out_valid[i]);
         end
      end
      out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         checks++;
         if (out_valid[1] !== 1'b0) begin
            errors++;
            $display("FAIL flush_leak c%0d: out_valid got %b want 0", c, out_valid[1]);
         end
      end
      in_valid = 1'b1; a = 32'd7; b = 32'd8;
      @(posedge clk); #1;
      in_valid = 1'b0;
      exp = {1'b1, 32'd15, 5'b00000};
      for (int t = 1; t <= 4; t++) begin
         for (int i = 0; i < 3; i++) begin
            if (LAT[i] == t) begin
               checks++;
               if (obs[i] !== exp) begin
                  errors++;
                  $display("FAIL flush_next S=%0d: got %h want %h", LAT[i], obs[i], exp);
               end
            end
         end
         if (t == 1) begin
            checks++;
            if (out_valid[1] !== 1'b0) begin
               errors++;
               $display("FAIL flush_latency: out_valid got %b want 0", out_valid[1]);
            end
         end
         if (t < 4) begin @(posedge clk); #1; end
      end
   endtask

   task automatic test_async_reset();
      logic [37:0] exp;
      out_ready = 1'b1; mode = ADD_MODE;
      in_valid = 1'b1; a = 32'd10; b = 32'd20;
      @(posedge clk); #1;
      a = 32'd30; b = 32'd40;
      @(posedge clk); #1;
      in_valid = 1'b0;
      #3;
      rst = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (obs[i] !== 38'h0) begin
            errors++;
            $display("FAIL async_rst S=%0d: got %h want 0", LAT[i], obs[i]);
         end
      end
      #1;
      rst = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b1; a = 32'd3; b = 32'd4;
      @(posedge clk); #1;
      in_valid = 1'b0;
      exp = {1'b1, 32'd7, 5'b00000};
      for (int t = 1; t <= 4; t++) begin
         for (int i = 0; i < 3; i++) begin
            if (LAT[i] == t) begin
               checks++;
               if (obs[i] !== exp) begin
                  errors++;
                  $display("FAIL rst_next S=%0d: got %h want %h", LAT[i], obs[i], exp);
               end
            end
         end
         if (t == 1) begin
            checks++;
            if (out_valid[1] !== 1'b0) begin
               errors++;
               $display("FAIL rst_stale: out_valid got %b want 0", out_valid[1]);
            end
         end
         if (t < 4) begin @(posedge clk); #1; end
      end
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; mode = ADD_MODE;
      test_reset();
      test_add_sub_cmp();
      test_back_to_back();
      test_flush();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

endmodule
